// File: rtl/seq_div.sv
// Sequential unsigned divider: 2N-bit dividend by N-bit divisor, radix-2 restoring,
// one quotient bit per clock, with a start/busy/done handshake.
module seq_div #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(2*N) + 1;
  localparam logic [CW-1:0] LAST = CW'(2*N-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [2*N-1:0] dq_reg;
  logic [N-1:0]   dvs_reg;
  logic [N:0]     pr_reg;
  logic [CW-1:0]  cnt_reg;
  logic           zero_reg;
  logic [2*N-1:0] quo_reg;
  logic [N-1:0]   rem_reg;
  logic           dbz_reg;

  logic [N:0]     pr_shift, pr_diff, pr_next;
  logic           q_bit;

  // dq_reg shifts the dividend out of its MSB while quotient bits enter at its LSB,
  // so after 2N steps it holds the complete quotient.
  always_comb begin
    pr_shift = {pr_reg[N-1:0], dq_reg[2*N-1]};
    pr_diff  = pr_shift - {1'b0, dvs_reg};
    q_bit    = pr_reg[N] | (pr_shift >= {1'b0, dvs_reg});
    pr_next  = q_bit ? pr_diff : pr_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_reg   <= '0;
      dvs_reg  <= '0;
      pr_reg   <= '0;
      cnt_reg  <= '0;
      zero_reg <= 1'b0;
      quo_reg  <= '0;
      rem_reg  <= '0;
      dbz_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            dq_reg   <= dividend;
            dvs_reg  <= divisor;
            pr_reg   <= '0;
            zero_reg <= (divisor == '0);
            // A zero divisor skips straight to the final step: one cycle to done.
            cnt_reg  <= (divisor == '0) ? LAST : '0;
          end
        end
        RUN: begin
          dq_reg  <= {dq_reg[2*N-2:0], q_bit};
          pr_reg  <= pr_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST) begin
            if (zero_reg) begin
              quo_reg <= '1;
              rem_reg <= '0;
              dbz_reg <= 1'b1;
            end else begin
              quo_reg <= {dq_reg[2*N-2:0], q_bit};
              rem_reg <= pr_next[N-1:0];
              dbz_reg <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quo_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (N=8): a cycle-level busy/done countdown model
// computing results with native / and %, plus directed literal expectations.
module tb_seq_div;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  seq_div #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: m_left counts the remaining busy cycles; results appear when it reaches 1.
  int          m_left = 0;
  logic [15:0] m_q = '0, p_q = '0;
  logic [7:0]  m_r = '0, p_r = '0;
  logic        m_z = 1'b0, p_z = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_q = '0; m_r = '0; m_z = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 1) begin m_q = p_q; m_r = p_r; m_z = p_z; end
    end else if (start) begin
      if (divisor == 0) begin
        p_q = 16'hFFFF; p_r = '0; p_z = 1'b1; m_left = 2;
      end else begin
        p_q = dividend / {8'd0, divisor}; p_r = 8'(dividend % {8'd0, divisor}); p_z = 1'b0;
        m_left = 2*N + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", busy, m_left > 0);
      chk("cyc_done", done, m_left == 1);
      chk("cyc_quotient", quotient, m_q);
      chk("cyc_remainder", remainder, m_r);
      chk("cyc_dbz", div_by_zero, m_z);
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                        input logic [7:0] er, input logic ez, input int lat, input bit poke);
    int acc, t, busy_n;
    @(negedge clk); start = 1'b1; dividend = a; divisor = b;
    @(negedge clk); start = 1'b0; acc = cyc;
    chk("accept_busy", busy, 1);
    busy_n = 1;
    dividend = 16'hBEEF; divisor = 8'd3;
    t = 0;
    while (!done && t < 40) begin
      start = poke && (t == 3);
      if (start) begin dividend = 16'd5; divisor = 8'd3; end
      @(negedge clk);
      t++;
      busy_n += int'(busy);
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("latency", cyc - acc, lat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, ez);
    if (poke) begin start = 1'b1; dividend = 16'd77; divisor = 8'd2; end
    @(negedge clk);
    start = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("busy_cycles", busy_n, lat + 1);
    repeat (2) @(negedge clk);
    chk("hold_quotient", quotient, eq);
    chk("hold_remainder", remainder, er);
  endtask

  initial begin
    int done_cnt, tmo, acc, prev_acc;
    logic [15:0] sa;
    logic [7:0]  sb;

    repeat (2) @(negedge clk);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    run_op(16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, 16, 1'b0);
    run_op(16'd65535, 8'd255, 16'd257,   8'd0, 1'b0, 16, 1'b0);
    run_op(16'd5,     8'd9,   16'd0,     8'd5, 1'b0, 16, 1'b0);
    run_op(16'd65535, 8'd1,   16'd65535, 8'd0, 1'b0, 16, 1'b0);
    run_op(16'd1234,  8'd0,   16'd65535, 8'd0, 1'b1, 1,  1'b0);
    run_op(16'd100,   8'd10,  16'd10,    8'd0, 1'b0, 16, 1'b0);
    run_op(16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, 16, 1'b1);

    // Reset in the middle of RUN.
    @(negedge clk); start = 1'b1; dividend = 16'd500; divisor = 8'd3;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    done_cnt = 0;
    repeat (20) begin @(negedge clk); done_cnt += int'(done); end
    chk("no_done_after_rst", done_cnt, 0);

    // Random back-to-back operations with start held high.
    prev_acc = 0;
    start = 1'b1;
    dividend = 16'($urandom); divisor = 8'($urandom_range(255, 1));
    for (int i = 0; i < 1000; i++) begin
      tmo = 0;
      while (busy && tmo < 40) begin @(negedge clk); tmo++; end
      while (!busy && tmo < 40) begin @(negedge clk); tmo++; end
      chk("rand_accept_seen", busy, 1);
      acc = cyc;
      if (i > 0) chk("rand_interval", acc - prev_acc, 2*N + 2);
      prev_acc = acc;
      sa = dividend; sb = divisor;
      dividend = 16'($urandom); divisor = 8'($urandom_range(255, 1));
      tmo = 0;
      while (!done && tmo < 40) begin @(negedge clk); tmo++; end
      chk("rand_done_seen", done, 1);
      chk("rand_identity", int'(quotient) * int'(sb) + int'(remainder), int'(sa));
      chk("rand_rem_lt_div", int'(remainder < sb), 1);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
